// File: rtl/fpu_pkg.sv
// Shared helpers for the pipelined FP adder: field extract/pack, flag indices, canonical NaN.
// Helpers work on 64-bit containers so any EXP_W/MAN_W up to 63 total bits fits.
package fpu_pkg;

    localparam int unsigned FLAG_INV = 2;
    localparam int unsigned FLAG_OVF = 1;
    localparam int unsigned FLAG_INX = 0;

    function automatic logic [63:0] field_mask(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] field_exp(input logic [63:0] x, input int unsigned exp_w,
                                              input int unsigned man_w);
        return (x >> man_w) & field_mask(exp_w);
    endfunction

    function automatic logic [63:0] field_frac(input logic [63:0] x, input int unsigned man_w);
        return x & field_mask(man_w);
    endfunction

    function automatic logic [63:0] pack_fp(input logic sign, input logic [63:0] exp,
                                            input logic [63:0] frac, input int unsigned exp_w,
                                            input int unsigned man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | ((exp & field_mask(exp_w)) << man_w) |
               (frac & field_mask(man_w));
    endfunction

    // Positive quiet NaN: exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
        return (field_mask(exp_w) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
    parameter int unsigned WIDTH = 28,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    always_comb begin
        count_o = CW'(WIDTH);
        // Later (higher) set bits override, leaving the MSB-most one.
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_add_pipe.sv
// 3-stage pipelined FP add/sub: S1 unpack/align, S2 add, S3 normalize/round/pack.
// Define FPU_RNE_EN for round-to-nearest-even; otherwise round toward zero.
module fpu_add_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [2:0]   out_flags
);

    localparam int unsigned SW = MAN_W + 4;  // hidden | frac | guard | round | sticky
    localparam int unsigned AW = MAN_W + 5;  // carry + SW
    localparam int unsigned CW = $clog2(AW + 1);
    localparam int unsigned EW = ((EXP_W > CW) ? EXP_W : CW) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, swap, s1_spec;
    logic [EXP_W-1:0] a_e, b_e, l_e, s_e, diff;
    logic [MAN_W-1:0] a_f, b_f, a_fz, b_fz;
    logic [SW-1:0]    a_sig, b_sig, l_sig, s_sig, s_aln;
    logic [2*SW-1:0]  wide;
    logic [31:0]      diff_x;
    logic [W-1:0]     s1_res;
    logic [2:0]       s1_flags;

    always_comb begin
        a_s   = in_a[W-1];
        b_s   = in_b[W-1] ^ in_sub;
        a_e   = EXP_W'(field_exp(64'(in_a), EXP_W, MAN_W));
        b_e   = EXP_W'(field_exp(64'(in_b), EXP_W, MAN_W));
        a_f   = MAN_W'(field_frac(64'(in_a), MAN_W));
        b_f   = MAN_W'(field_frac(64'(in_b), MAN_W));
        a_nan = (a_e == EXP_MAX) && (a_f != '0);
        b_nan = (b_e == EXP_MAX) && (b_f != '0);
        a_inf = (a_e == EXP_MAX) && (a_f == '0);
        b_inf = (b_e == EXP_MAX) && (b_f == '0);
        // exp=0 means zero or denormal; both flush to signed zero.
        a_fz  = (a_e == '0) ? '0 : a_f;
        b_fz  = (b_e == '0) ? '0 : b_f;
        a_sig = {a_e != '0, a_fz, 3'b000};
        b_sig = {b_e != '0, b_fz, 3'b000};
        swap  = {b_e, b_fz} > {a_e, a_fz};
        l_e   = swap ? b_e : a_e;
        s_e   = swap ? a_e : b_e;
        l_sig = swap ? b_sig : a_sig;
        s_sig = swap ? a_sig : b_sig;
        diff  = l_e - s_e;
        diff_x = 32'(diff);
        wide  = {s_sig, {SW{1'b0}}} >> diff;
        if (diff_x >= MAN_W + 3) begin
            s_aln = {{(SW-1){1'b0}}, |s_sig};
        end else begin
            s_aln = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};
        end

        s1_spec  = 1'b0;
        s1_res   = '0;
        s1_flags = '0;
        if (a_nan || b_nan) begin
            s1_spec  = 1'b1;
            s1_res   = W'(canon_nan(EXP_W, MAN_W));
            s1_flags[FLAG_INV] = (a_nan && !a_f[MAN_W-1]) || (b_nan && !b_f[MAN_W-1]);
        end else if (a_inf && b_inf && (a_s != b_s)) begin
            s1_spec  = 1'b1;
            s1_res   = W'(canon_nan(EXP_W, MAN_W));
            s1_flags[FLAG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            s1_spec  = 1'b1;
            s1_res   = W'(pack_fp(a_inf ? a_s : b_s, 64'(EXP_MAX), 64'd0, EXP_W, MAN_W));
        end
    end

    logic             v1_q, spec1_q, sign1_q, sub1_q;
    logic [W-1:0]     sres1_q;
    logic [2:0]       sflg1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [SW-1:0]    sigl1_q, sigs1_q;

    // ---------------- S2: significand add/subtract ----------------
    logic [AW-1:0] s2_sum;
    logic          s2_sign;

    always_comb begin
        s2_sum  = sub1_q ? ({1'b0, sigl1_q} - {1'b0, sigs1_q})
                         : ({1'b0, sigl1_q} + {1'b0, sigs1_q});
        s2_sign = (sub1_q && (s2_sum == '0)) ? 1'b0 : sign1_q;
    end

    logic             v2_q, spec2_q, sign2_q;
    logic [W-1:0]     sres2_q;
    logic [2:0]       sflg2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [AW-1:0]    sum2_q;

    // ---------------- S3: normalize, round, pack ----------------
    logic [CW-1:0]  lz;
    logic [SW-1:0]  norm;
    logic [EW-1:0]  exp_x, lz_x, e_n, e_r;
    logic [MAN_W:0] rnd;
    logic           carry, underflow, round_up, rnd_carry, inexact;
    logic [W-1:0]   s3_res;
    logic [2:0]     s3_flags;

    fpu_lzc #(.WIDTH(AW)) u_lzc (
        .data_i  (sum2_q),
        .count_o (lz)
    );

    always_comb begin
        exp_x     = EW'(exp2_q);
        lz_x      = EW'(lz);
        carry     = sum2_q[AW-1];
        underflow = !carry && (exp_x < lz_x);
        if (carry) begin
            norm = SW'(sum2_q >> 1) | {{(SW-1){1'b0}}, sum2_q[0]};
            e_n  = exp_x + EW'(1);
        end else begin
            norm = SW'(sum2_q << (lz - CW'(1)));
            e_n  = exp_x - lz_x + EW'(1);
        end
        inexact = |norm[2:0];
`ifdef FPU_RNE_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
        round_up = 1'b0;
`endif
        rnd       = norm[SW-1:3] + {{MAN_W{1'b0}}, round_up};
        // Hidden bit wrapping to 0 means the fraction rounded up past all-ones.
        rnd_carry = norm[SW-1] & ~rnd[MAN_W];
        e_r       = e_n + EW'(rnd_carry);

        s3_res   = '0;
        s3_flags = '0;
        if (spec2_q) begin
            s3_res   = sres2_q;
            s3_flags = sflg2_q;
        end else if (sum2_q == '0) begin
            s3_res = W'(pack_fp(sign2_q, 64'd0, 64'd0, EXP_W, MAN_W));
        end else if (underflow) begin
            s3_res = W'(pack_fp(sign2_q, 64'd0, 64'd0, EXP_W, MAN_W));
            s3_flags[FLAG_INX] = 1'b1;
        end else if (e_r >= EW'(EXP_MAX)) begin
            s3_flags[FLAG_OVF] = 1'b1;
            s3_flags[FLAG_INX] = 1'b1;
`ifdef FPU_RNE_EN
            s3_res = W'(pack_fp(sign2_q, 64'(EXP_MAX), 64'd0, EXP_W, MAN_W));
`else
            s3_res = W'(pack_fp(sign2_q, 64'(EXP_MAX - 1'b1), 64'({MAN_W{1'b1}}), EXP_W, MAN_W));
`endif
        end else begin
            s3_res = W'(pack_fp(sign2_q, 64'(e_r), 64'(rnd), EXP_W, MAN_W));
            s3_flags[FLAG_INX] = inexact;
        end
    end

    logic         v3_q;
    logic [W-1:0] out_q;
    logic [2:0]   flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else if (advance) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                out_q   <= s3_res;
                flags_q <= s3_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            spec1_q <= s1_spec;
            sres1_q <= s1_res;
            sflg1_q <= s1_flags;
            sign1_q <= swap ? b_s : a_s;
            sub1_q  <= a_s ^ b_s;
            exp1_q  <= l_e;
            sigl1_q <= l_sig;
            sigs1_q <= s_aln;
            spec2_q <= spec1_q;
            sres2_q <= sres1_q;
            sflg2_q <= sflg1_q;
            sign2_q <= s2_sign;
            exp2_q  <= exp1_q;
            sum2_q  <= s2_sum;
        end
    end

    assign out_valid = v3_q;
    assign out       = out_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_fpu_add_pipe.sv
// Scoreboard bench for fpu_add_pipe: single and half-like formats, stalls, mid-flight reset.
module tb_fpu_add_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out;
    logic [2:0]  out_flags;

    logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out;
    logic [2:0]  h_out_flags;

    int n_checks = 0;
    int n_errors = 0;
    int n_rx = 0;

    logic [34:0] exp_q[$];
    logic [34:0] h_q[$];
    logic [34:0] pop_v, h_pop_v;

    always #5 clk = ~clk;

    fpu_add_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    fpu_add_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .in_a      (h_in_a),
        .in_b      (h_in_b),
        .in_sub    (h_in_sub),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .out       (h_out),
        .out_flags (h_out_flags)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] ex(input logic [31:0] r, input logic [2:0] f);
        return {f, r};
    endfunction

    // Main-DUT monitor: compare on transfer, check holding and in_ready during stalls.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!out_ready) begin
                check_eq("in_ready_stall", 64'(in_ready), 64'd0);
                if (exp_q.size() > 0)
                    check_eq("hold", 64'({out_flags, out}), 64'(exp_q[0]));
            end else if (exp_q.size() == 0) begin
                check_eq("spurious", 64'(exp_q.size()), 64'd1);
            end else begin
                pop_v = exp_q.pop_front();
                check_eq($sformatf("res%0d", n_rx), 64'({out_flags, out}), 64'(pop_v));
                n_rx++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && h_out_valid) begin
            if (h_q.size() == 0) begin
                check_eq("h_spurious", 64'(h_q.size()), 64'd1);
            end else begin
                h_pop_v = h_q.pop_front();
                check_eq("h_res", 64'({h_out_flags, 16'd0, h_out}), 64'(h_pop_v));
            end
        end
    end

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [34:0] e);
        int n = 0;
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("accept", 64'(in_ready), 64'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic h_send(input logic [15:0] a, input logic [15:0] b, input logic [34:0] e);
        h_in_a = a;
        h_in_b = b;
        h_in_sub = 1'b0;
        h_in_valid = 1'b1;
        @(negedge clk);
        if (!h_in_ready) check_eq("h_accept", 64'(h_in_ready), 64'd1);
        else h_q.push_back(e);
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || h_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("drain", 64'(exp_q.size() + h_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        h_in_valid = 1'b0;
        h_in_a = '0;
        h_in_b = '0;
        h_in_sub = 1'b0;
        h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out", 64'(out), 64'd0);
        check_eq("rst_flags", 64'(out_flags), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed operations, streamed back-to-back.
        send(32'h3F800000, 32'h40000000, 1'b0, ex(32'h40400000, 3'b000));
        send(32'h3F800000, 32'h3F800000, 1'b1, ex(32'h00000000, 3'b000));
        send(32'h7F800000, 32'hFF800000, 1'b0, ex(32'h7FC00000, 3'b100));
`ifdef FPU_RNE_EN
        send(32'h3F800000, 32'h33C00000, 1'b0, ex(32'h3F800001, 3'b001));
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, ex(32'h7F800000, 3'b011));
`else
        send(32'h3F800000, 32'h33C00000, 1'b0, ex(32'h3F800000, 3'b001));
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, ex(32'h7F7FFFFF, 3'b011));
`endif
        send(32'h3F800000, 32'h33800000, 1'b0, ex(32'h3F800000, 3'b001));  // exact tie
        send(32'h3F800000, 32'h30800000, 1'b0, ex(32'h3F800000, 3'b001));  // sticky only
        send(32'h3F800000, 32'h3F400000, 1'b1, ex(32'h3E800000, 3'b000));
        send(32'h00800000, 32'h00800001, 1'b1, ex(32'h80000000, 3'b001));  // underflow
        send(32'h00000001, 32'h3F800000, 1'b0, ex(32'h3F800000, 3'b000));  // denormal flush
        send(32'h7F800001, 32'h3F800000, 1'b0, ex(32'h7FC00000, 3'b100));  // sNaN
        send(32'h7FC00000, 32'h3F800000, 1'b0, ex(32'h7FC00000, 3'b000));  // qNaN
        send(32'h3F800000, 32'h7F800000, 1'b1, ex(32'hFF800000, 3'b000));  // 1 - inf
        send(32'hC0000000, 32'h3F800000, 1'b0, ex(32'hBF800000, 3'b000));
        drain();

        // Backpressure: 5 back-to-back adds, consumer stalls for 7 cycles.
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, ex(32'h40000000, 3'b000));
                send(32'h40000000, 32'h3F800000, 1'b0, ex(32'h40400000, 3'b000));
                send(32'h40400000, 32'h3F800000, 1'b0, ex(32'h40800000, 3'b000));
                send(32'h40800000, 32'h3F800000, 1'b0, ex(32'h40A00000, 3'b000));
                send(32'h40A00000, 32'h3F800000, 1'b0, ex(32'h40C00000, 3'b000));
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_eq("rx_total", 64'(n_rx), 64'd19);

        // Reset with two operations in flight: nothing may emerge afterwards.
        send(32'h3F800000, 32'h40000000, 1'b0, ex(32'h40400000, 3'b000));
        send(32'h40000000, 32'h40000000, 1'b0, ex(32'h40800000, 3'b000));
        in_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("rst_flush_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("rst_no_stale", 64'(n_rx), 64'd19);

        // Reduced format (EXP_W=5, MAN_W=10).
        h_send(16'h3C00, 16'h4000, {3'b000, 16'd0, 16'h4200});
`ifdef FPU_RNE_EN
        h_send(16'h7BFF, 16'h7BFF, {3'b011, 16'd0, 16'h7C00});
`else
        h_send(16'h7BFF, 16'h7BFF, {3'b011, 16'd0, 16'h7BFF});
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
